// File: rtl/quire_to_posit_4_0.sv
// rtl/quire_to_posit_4_0.sv - quire accumulator word to rounded posit<4,0>, three-stage rts/rtr pipeline
module quire_to_posit_4_0 #(
  parameter int LOG_NB_ACCUM = 10,
  parameter bit EOW_ONLY = 1'b1,
  localparam int QUIRE_SIZE = 9 + LOG_NB_ACCUM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  rtr_o,
  input  logic                  rts_i,
  input  logic                  sow_i,
  input  logic                  eow_i,
  input  logic [QUIRE_SIZE-1:0] data_i,
  input  logic                  sign_i,
  input  logic                  zero_i,
  input  logic                  NaR_i,
  input  logic                  rtr_i,
  output logic                  rts_o,
  output logic                  sow_o,
  output logic                  eow_o,
  output logic [3:0]            posit_o,
  output logic                  NaR_o,
  output logic                  zero_o,
  output logic                  sign_o
);

  logic                  process_en;
  logic                  accept;
  logic                  fwd;
  logic [QUIRE_SIZE-1:0] mag_in;
  logic                  unused_sign;

  logic                  s1_v, s1_sow, s1_eow, s1_nar, s1_zero, s1_neg;
  logic [QUIRE_SIZE-1:0] s1_mag;

  logic                  s2_v, s2_sow, s2_eow, s2_nar, s2_zero, s2_neg;
  logic [6:0]            s2_m;

  logic [6:0]            m_sat;
  logic [3:0]            p_mag;
  logic [3:0]            posit_nxt;

  // data_i MSB is the authoritative sign; sign_i is only informative
  assign unused_sign = sign_i;

  assign process_en = rtr_i | ~rts_o;
  assign accept     = rts_i & rtr_o & process_en;
  assign fwd        = accept & (eow_i | ~EOW_ONLY);

  // Unsigned magnitude: the most negative quire maps to 2^(QUIRE_SIZE-1) without overflow
  assign mag_in = data_i[QUIRE_SIZE-1] ? (~data_i + QUIRE_SIZE'(1)) : data_i;

  assign m_sat = ((|s1_mag[QUIRE_SIZE-1:7]) || (s1_mag[6:0] > 7'd64)) ? 7'd64 : s1_mag[6:0];

  // Thresholds already fold in ties-to-even on the posit bit string
  always_comb begin
    p_mag = 4'b0000;
    if (s2_m == 7'd0)       p_mag = 4'b0000;
    else if (s2_m <= 7'd5)  p_mag = 4'b0001;
    else if (s2_m <= 7'd10) p_mag = 4'b0010;
    else if (s2_m <= 7'd13) p_mag = 4'b0011;
    else if (s2_m <= 7'd20) p_mag = 4'b0100;
    else if (s2_m <= 7'd27) p_mag = 4'b0101;
    else if (s2_m <= 7'd48) p_mag = 4'b0110;
    else                    p_mag = 4'b0111;
  end

  always_comb begin
    posit_nxt = 4'b0000;
    if (s2_nar)
      posit_nxt = 4'b1000;
    else if (s2_zero || (s2_m == 7'd0))
      posit_nxt = 4'b0000;
    else if (s2_neg)
      posit_nxt = 4'd0 - p_mag;
    else
      posit_nxt = p_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtr_o   <= 1'b0;
      s1_v    <= 1'b0;
      s1_sow  <= 1'b0;
      s1_eow  <= 1'b0;
      s1_nar  <= 1'b0;
      s1_zero <= 1'b0;
      s1_neg  <= 1'b0;
      s1_mag  <= '0;
      s2_v    <= 1'b0;
      s2_sow  <= 1'b0;
      s2_eow  <= 1'b0;
      s2_nar  <= 1'b0;
      s2_zero <= 1'b0;
      s2_neg  <= 1'b0;
      s2_m    <= 7'd0;
      rts_o   <= 1'b0;
      sow_o   <= 1'b0;
      eow_o   <= 1'b0;
      posit_o <= 4'b0000;
    end else begin
      rtr_o <= process_en;
      if (process_en) begin
        s1_v    <= fwd;
        s1_sow  <= sow_i;
        s1_eow  <= eow_i;
        s1_nar  <= NaR_i;
        s1_zero <= zero_i;
        s1_neg  <= data_i[QUIRE_SIZE-1];
        s1_mag  <= mag_in;
        s2_v    <= s1_v;
        s2_sow  <= s1_sow;
        s2_eow  <= s1_eow;
        s2_nar  <= s1_nar;
        s2_zero <= s1_zero;
        s2_neg  <= s1_neg;
        s2_m    <= m_sat;
        rts_o   <= s2_v;
        sow_o   <= s2_sow;
        eow_o   <= s2_eow;
        posit_o <= posit_nxt;
      end
    end
  end

  assign NaR_o  = (posit_o == 4'b1000);
  assign zero_o = (posit_o == 4'b0000);
  assign sign_o = posit_o[3];

endmodule
